// File: rtl/adder_pkg.sv
// Shared constants for the adder-sharing block: operand/result widths,
// operation mode encodings and FSM state codes.
package adder_pkg;

    localparam int WIDTH = 18;
    localparam int RES_W = WIDTH + 1;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request scanning
// upward from the slot after the previous winner, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               grant_vld_o
);

    always_comb begin
        int idx;
        idx         = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_grant_i) + off) % NUM_REQ;
            if (!grant_vld_o && req_i[idx]) begin
                grant_vld_o  = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_adder.sv
// Single shared add/subtract datapath; the result carries one extra bit
// holding the carry (add) or borrow/sign (subtract).
module shared_adder
    import adder_pkg::*;
#(
    parameter int W = 18
) (
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic         mode,
    output logic [W:0]   out
);

    always_comb begin
        if (mode == MODE_SUB) out = {1'b0, in1} - {1'b0, in2};
        else                  out = {1'b0, in1} + {1'b0, in2};
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one adder between NUM_REQ valid/ready requesters using round-robin
// arbitration; one operation in flight at a time (grant, compute, respond).
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int WIDTH   = 18,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_mode,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH:0]           rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy,
    output logic [CNT_W-1:0]         op_count
);
    import adder_pkg::*;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [ID_W-1:0]  gid_q, gid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic [WIDTH:0]   data_q, data_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gidx;
    logic               gvld;
    logic [WIDTH:0]     sum;
    logic               hs;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .grant_o      (grant),
        .grant_idx_o  (gidx),
        .grant_vld_o  (gvld)
    );

    shared_adder #(
        .W (WIDTH)
    ) u_add (
        .in1  (a_q),
        .in2  (b_q),
        .mode (mode_q),
        .out  (sum)
    );

    // Ready is suppressed while reset is held so nothing is accepted then.
    assign req_ready = (rst_n && state_q == ST_IDLE) ? grant : '0;
    assign hs        = gvld && |(req_valid & req_ready);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gid_d   = gid_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        data_d  = data_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    a_d     = req_a[int'(gidx)*WIDTH +: WIDTH];
                    b_d     = req_b[int'(gidx)*WIDTH +: WIDTH];
                    mode_d  = req_mode[gidx];
                    gid_d   = gidx;
                    last_d  = gidx;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                data_d  = sum;
                id_d    = gid_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Last grant resets to the top slot so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= ID_W'(NUM_REQ - 1);
            gid_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= MODE_ADD;
            data_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign op_count  = cnt_q;

endmodule
